// File: rtl/watchdog_pkg.sv
// Shared types and helpers for the multi-channel windowed watchdog.
// Channel FSM states and the ms-to-cycles conversion used at elaboration.
package watchdog_pkg;

  typedef enum logic [1:0] {
    DISABLED,
    WINDOW,
    OPEN,
    EXPIRED
  } wd_state_e;

  // Computed in 64 bits: the default 50 MHz * 100 ms product overflows 32 bits.
  function automatic int ms_to_cycles(input longint freq, input longint ms);
    return int'((freq * ms) / 64'd1000);
  endfunction

endpackage

// File: rtl/watchdog_channel.sv
// One watchdog channel: kick pipeline, saturating down-counter and window FSM.
// Raises a sticky (or kick-cleared) timeout flag and an early-kick flag.
module watchdog_channel
  import watchdog_pkg::*;
#(
  parameter int T             = 10,
  parameter int W             = 0,
  parameter int EdgeSensitive = 1,
  parameter int Sticky        = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic kick_in,
  input  logic clear,
  output logic timeout,
  output logic early
);

  localparam int N = (T > 1) ? $clog2(T) : 1;
  localparam logic [N-1:0] RELOAD  = N'(T - 1);
  localparam logic [N-1:0] WIN_END = N'(T - 1 - W);

  wd_state_e      state_q, state_d;
  logic [N-1:0]   count_q, count_d;
  logic [N-1:0]   count_dec;
  logic [1:0]     kick_q;
  logic           kick;
  logic           timeout_d, early_d;
  logic           timeout_set, early_set, valid_kick, flag_drop;

  assign kick      = (EdgeSensitive != 0) ? (kick_q[0] & ~kick_q[1]) : kick_q[0];
  assign count_dec = count_q - N'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DISABLED;
      count_q <= RELOAD;
      kick_q  <= 2'b00;
      timeout <= 1'b0;
      early   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      kick_q  <= {kick_q[0], kick_in};
      timeout <= timeout_d;
      early   <= early_d;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (!enable) begin
      state_d = DISABLED;
      count_d = RELOAD;
    end else begin
      case (state_q)
        DISABLED: begin
          state_d = OPEN;
          count_d = RELOAD;
        end
        WINDOW: begin
          if (kick) begin
            count_d = RELOAD;
          end else begin
            count_d = count_dec;
            if (count_dec == WIN_END) state_d = OPEN;
          end
        end
        OPEN: begin
          if (kick) begin
            count_d = RELOAD;
            state_d = (W > 0) ? WINDOW : OPEN;
          end else if (count_q == '0) begin
            state_d = EXPIRED;
          end else begin
            count_d = count_dec;
          end
        end
        EXPIRED: begin
          if (kick) begin
            count_d = RELOAD;
            state_d = OPEN;
          end
        end
        default: begin
          state_d = DISABLED;
          count_d = RELOAD;
        end
      endcase
    end
  end

  // Set events beat clears; a kick coinciding with Count==0 suppresses the timeout.
  always_comb begin
    timeout_set = enable && (state_q == OPEN) && (count_q == '0) && !kick;
    early_set   = enable && (state_q == WINDOW) && kick;
    valid_kick  = enable && kick && ((state_q == OPEN) || (state_q == EXPIRED));
    flag_drop   = clear || ((Sticky == 0) && valid_kick);
    timeout_d   = timeout_set | (timeout & ~flag_drop);
    early_d     = early_set | (early & ~flag_drop);
  end

endmodule

// File: rtl/multi_watchdog.sv
// Multi-channel windowed watchdog: one watchdog_channel per kick source.
// opError summarises every channel's timeout and early flags for the reset sequencer.
module multi_watchdog
  import watchdog_pkg::*;
#(
  parameter int Clk_Frequency = 50000000,
  parameter int Timeout_ms    = 100,
  parameter int Window_ms     = 0,
  parameter int Channels      = 4,
  parameter int EdgeSensitive = 1,
  parameter int Sticky        = 1
) (
  input  logic                ipClk,
  input  logic                Reset,
  input  logic [Channels-1:0] ipEnable,
  input  logic [Channels-1:0] ipKick,
  input  logic                ipClear,
  output logic [Channels-1:0] opTimeout,
  output logic [Channels-1:0] opEarly,
  output logic                opError
);

  localparam int T = ms_to_cycles(Clk_Frequency, Timeout_ms);
  localparam int W = ms_to_cycles(Clk_Frequency, Window_ms);

  if (T < 2) begin : g_bad_timeout
    $error("multi_watchdog: timeout must be at least 2 cycles");
  end
  if (W >= T) begin : g_bad_window
    $error("multi_watchdog: early window must be shorter than the timeout");
  end
  if ((Channels < 1) || (Channels > 32)) begin : g_bad_channels
    $error("multi_watchdog: Channels must be in 1..32");
  end

  for (genvar i = 0; i < Channels; i++) begin : g_ch
    watchdog_channel #(
      .T             (T),
      .W             (W),
      .EdgeSensitive (EdgeSensitive),
      .Sticky        (Sticky)
    ) u_ch (
      .clk     (ipClk),
      .reset   (Reset),
      .enable  (ipEnable[i]),
      .kick_in (ipKick[i]),
      .clear   (ipClear),
      .timeout (opTimeout[i]),
      .early   (opEarly[i])
    );
  end

  assign opError = (|opTimeout) | (|opEarly);

endmodule
